// File: rtl/dmem_refill_responder.sv
// dmem_refill_responder
//   Shared word-addressed data memory at the far end of the L1 miss/refill
//   interface. Serves refill reads and word write-throughs from NUM_REQ L1
//   caches strictly one at a time, picks requesters round-robin, spends
//   MEM_LATENCY cycles in the array access and answers with a one-cycle
//   rsp_valid pulse to the granted cache.
//   Build macro: DMEM_WRITE_ACK_EN -- when defined, writes are acknowledged
//   with an rsp_valid pulse carrying the written word; when undefined, writes
//   complete silently and return straight to IDLE.
module dmem_refill_responder #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      busy
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WIDX_W = ADDR_W - 2;
  localparam int DEPTH  = 2 ** WIDX_W;
  localparam int CNT_W  = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESPOND
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    gnt_q, gnt_d;
  logic                we_q, we_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;

  logic                arb_found;
  logic [IDX_W-1:0]    arb_idx;
  int                  cand_int;
  logic [IDX_W-1:0]    cand;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                unused_sel_addr_lsbs;
  logic [IDX_W-1:0]    gnt_next;

  // Round-robin pick: first pending requester at or above rr_ptr, wrapping.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    arb_found = 1'b0;
    arb_idx   = '0;
    cand_int  = 0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_int = (int'(rr_ptr_q) + k) % NUM_REQ;
      cand     = IDX_W'(cand_int);
      if (!arb_found && req_valid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // Route the winning requester's command fields out of the flat buses.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == arb_idx) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Byte lanes are merged in the L1, so the low address bits carry no meaning here.
  assign unused_sel_addr_lsbs = ^sel_addr[1:0];

  // Requester that gets the first look at the next arbitration.
  assign gnt_next = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);

  // Transaction FSM: next state, captured command, array strobes and handshakes.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = gnt_q;
    we_d      = we_q;
    widx_d    = widx_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    mem_we    = 1'b0;
    req_ready = '0;
    rsp_valid = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          req_ready[arb_idx] = 1'b1;
          gnt_d              = arb_idx;
          we_d               = sel_we;
          widx_d             = sel_addr[ADDR_W-1:2];
          wdata_d            = sel_wdata;
          cnt_d              = CNT_W'(MEM_LATENCY);
          state_d            = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        cnt_d = cnt_q - CNT_W'(1);
        // The array is touched only in the last ACCESS cycle, so a reset
        // earlier in the transaction discards a pending write.
        if (cnt_q == CNT_W'(1)) begin
          rr_ptr_d = gnt_next;
          if (we_q) begin
            mem_we = 1'b1;
`ifdef DMEM_WRITE_ACK_EN
            rdata_d = wdata_q;
            state_d = ST_RESPOND;
`else
            state_d = ST_IDLE;
`endif
          end else begin
            rdata_d = mem_q[widx_q];
            state_d = ST_RESPOND;
          end
        end
      end

      ST_RESPOND: begin
        rsp_valid[gnt_q] = 1'b1;
        state_d          = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Control and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      we_q     <= 1'b0;
      widx_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      widx_q   <= widx_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
    end
  end

  // Word array write port.
  // NOTE: the storage array has no reset so it can map onto a RAM macro;
  // its contents are undefined until written.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[widx_q] <= wdata_q;
    end
  end

  assign rsp_rdata = rdata_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dmem_refill_responder.sv
// Self-checking bench for dmem_refill_responder. Expected behaviour comes
// from a word-level memory model, a round-robin "last granted" model and the
// fixed timing rules (response at accept+L+1, next accept at accept+L+2, or
// accept+L+1 after a silent write). Works with or without DMEM_WRITE_ACK_EN.
module tb_dmem_refill_responder;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 32;
  localparam int L       = 2;
`ifdef DMEM_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif
  localparam int PERIOD  = L + 2;
  localparam int WPERIOD = ACK ? L + 2 : L + 1;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state.
  logic [DATA_W-1:0] model_mem [int];
  int                last_grant;
  logic [DATA_W-1:0] held_rdata;

  typedef struct {
    int                 t;
    logic [NUM_REQ-1:0] v;
    logic [DATA_W-1:0]  d;
  } rsp_t;
  rsp_t rsp_log[$];

  dmem_refill_responder #(
    .NUM_REQ    (NUM_REQ),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .MEM_LATENCY(L)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every response pulse with the cycle it was seen in.
  always @(negedge clk) begin
    rsp_t e;
    if (rsp_valid !== '0) begin
      e.t = cyc;
      e.v = rsp_valid;
      e.d = rsp_rdata;
      rsp_log.push_back(e);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int word_of(input logic [ADDR_W-1:0] a);
    return int'(a[ADDR_W-1:2]);
  endfunction

  function automatic int rr_pick(input logic [NUM_REQ-1:0] v);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int c;
      c = (last_grant + k) % NUM_REQ;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic int count_rsp_after(input int t0);
    int n;
    n = 0;
    foreach (rsp_log[i]) if (rsp_log[i].t > t0) n++;
    return n;
  endfunction

  task automatic drive(input int r, input bit we, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    req_we[r]                     = we;
    req_addr[r*ADDR_W +: ADDR_W]  = a;
    req_wdata[r*DATA_W +: DATA_W] = d;
  endtask

  task automatic wait_ready(input int r, input string name, output int t);
    t = -1;
    for (int k = 0; k < 40 && t < 0; k++) begin
      @(negedge clk);
      if (req_ready[r] === 1'b1) t = cyc;
    end
    if (t < 0) begin
      checks++;
      errors++;
      $display("FAIL %s: req_ready[%0d] not seen within 40 cycles", name, r);
    end
  endtask

  task automatic wait_any_ready(input string name, output int idx);
    idx = -1;
    for (int k = 0; k < 40 && idx < 0; k++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) if (idx < 0 && req_ready[i] === 1'b1) idx = i;
    end
    if (idx < 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no req_ready within 40 cycles", name);
    end
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    last_grant = NUM_REQ - 1;
    held_rdata = '0;
  endtask

  // One isolated transaction, checked against the model.
  task automatic txn(input int r, input bit we, input logic [ADDR_W-1:0] addr,
                     input logic [DATA_W-1:0] wdata, input string name);
    int t, n;
    bit exp_rsp;
    logic [DATA_W-1:0] exp_d;
    logic [NUM_REQ-1:0] oh;
    rsp_t e;
    e = '{t: -1, v: '0, d: '0};
    oh = '0;
    oh[r] = 1'b1;
    @(posedge clk);
    #1;
    drive(r, we, addr, wdata);
    req_valid[r] = 1'b1;
    wait_ready(r, name, t);
    @(posedge clk);
    #1 req_valid[r] = 1'b0;
    if (t < 0) return;
    last_grant = r;
    if (we) begin
      model_mem[word_of(addr)] = wdata;
      exp_d   = wdata;
      exp_rsp = ACK;
    end else begin
      exp_d   = model_mem.exists(word_of(addr)) ? model_mem[word_of(addr)] : 'x;
      exp_rsp = 1'b1;
    end
    while (cyc < t + L + 3) @(negedge clk);
    n = 0;
    foreach (rsp_log[i]) if (rsp_log[i].t > t) begin n++; e = rsp_log[i]; end
    checks++;
    if (n != (exp_rsp ? 1 : 0))
      begin errors++; $display("FAIL %s_count: got %0d pulses, expected %0d", name, n, exp_rsp ? 1 : 0); end
    if (exp_rsp && n == 1) begin
      checks++;
      if (e.t !== t + L + 1)
        begin errors++; $display("FAIL %s_time: rsp at %0d, expected %0d", name, e.t, t + L + 1); end
      checks++;
      if (e.v !== oh)
        begin errors++; $display("FAIL %s_onehot: rsp_valid %b, expected %b", name, e.v, oh); end
      checks++;
      if (e.d !== exp_d)
        begin errors++; $display("FAIL %s_data: got %h, expected %h", name, e.d, exp_d); end
    end
    if (exp_rsp) held_rdata = exp_d;
    else begin
      checks++;
      if (rsp_rdata !== held_rdata)
        begin errors++; $display("FAIL %s_hold: rsp_rdata %h, expected %h", name, rsp_rdata, held_rdata); end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req_valid = '0;
    req_we = '0;
    req_addr = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL rst_ready: got %b, expected 0", req_ready); end
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL rst_rsp_valid: got %b, expected 0", rsp_valid); end
    checks++; if (rsp_rdata !== '0) begin errors++; $display("FAIL rst_rdata: got %h, expected 0", rsp_rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, expected 0", busy); end
    @(posedge clk);
    #1 reset = 1'b0;
    last_grant = NUM_REQ - 1;
    held_rdata = '0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_write_read;
    txn(0, 1'b1, 10'h010, 32'hDEADBEEF, "wr_write");
    txn(1, 1'b0, 10'h013, 32'h0, "wr_read");
  endtask

  task automatic arb_round(input string name);
    int g1, g2, exp1, exp2;
    @(posedge clk);
    #1;
    for (int r = 0; r < NUM_REQ; r++) drive(r, 1'b0, 10'h010, 32'h0);
    req_valid = '1;
    exp1 = rr_pick(req_valid);
    wait_any_ready({name, "_first"}, g1);
    if (g1 < 0) begin req_valid = '0; return; end
    checks++;
    if (g1 != exp1) begin errors++; $display("FAIL %s_first: granted %0d, expected %0d", name, g1, exp1); end
    last_grant = exp1;
    @(posedge clk);
    #1 req_valid[g1] = 1'b0;
    exp2 = rr_pick(req_valid);
    wait_any_ready({name, "_second"}, g2);
    if (g2 >= 0) begin
      checks++;
      if (g2 != exp2) begin errors++; $display("FAIL %s_second: granted %0d, expected %0d", name, g2, exp2); end
      last_grant = exp2;
    end
    @(posedge clk);
    #1 req_valid = '0;
    repeat (L + 3) @(negedge clk);
    held_rdata = model_mem[word_of(10'h010)];
  endtask

  task automatic test_arbitration;
    pulse_reset();
    arb_round("arb_r1");
    // A lone grant to req0 leaves req1 next in line for the second contest.
    txn(0, 1'b0, 10'h010, 32'h0, "arb_solo");
    arb_round("arb_r2");
  endtask

  task automatic test_throughput;
    int t0, n;
    bit exp_rdy;
    @(posedge clk);
    #1;
    drive(0, 1'b0, 10'h013, 32'h0);
    req_valid[0] = 1'b1;
    wait_ready(0, "thr_first", t0);
    if (t0 >= 0) begin
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL thr_busy0: got %b, expected 0", busy); end
      for (int c = 1; c <= 4 * PERIOD; c++) begin
        @(negedge clk);
        exp_rdy = (c % PERIOD == 0);
        checks++;
        if (req_ready[0] !== exp_rdy)
          begin errors++; $display("FAIL thr_ready@+%0d: got %b, expected %b", c, req_ready[0], exp_rdy); end
        checks++;
        if (busy !== !exp_rdy)
          begin errors++; $display("FAIL thr_busy@+%0d: got %b, expected %b", c, busy, !exp_rdy); end
      end
    end
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    last_grant = 0;
    if (t0 < 0) return;
    while (cyc < t0 + 4 * PERIOD + L + 3) @(negedge clk);
    n = 0;
    foreach (rsp_log[i])
      if (rsp_log[i].t > t0 && rsp_log[i].d === model_mem[word_of(10'h013)] && rsp_log[i].v === 2'b01) n++;
    checks++;
    if (n != 5) begin errors++; $display("FAIL thr_rsp: got %0d good responses, expected 5", n); end
    held_rdata = model_mem[word_of(10'h013)];
  endtask

  task automatic test_write_ack;
    int t1, t2, n;
    logic [DATA_W-1:0] rd_at_accept, exp_hold;
    rsp_t first;
    first = '{t: -1, v: '0, d: '0};
    exp_hold = ACK ? 32'hCAFEF00D : held_rdata;
    @(posedge clk);
    #1;
    drive(0, 1'b1, 10'h3FC, 32'hCAFEF00D);
    req_valid[0] = 1'b1;
    wait_ready(0, "wa_write", t1);
    @(posedge clk);
    #1 req_we[0] = 1'b0;
    wait_ready(0, "wa_read", t2);
    rd_at_accept = rsp_rdata;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    last_grant = 0;
    if (t1 < 0 || t2 < 0) return;
    model_mem[word_of(10'h3FC)] = 32'hCAFEF00D;
    checks++;
    if (t2 != t1 + WPERIOD) begin errors++; $display("FAIL wa_period: accept at +%0d, expected +%0d", t2 - t1, WPERIOD); end
    checks++;
    if (rd_at_accept !== exp_hold) begin errors++; $display("FAIL wa_hold: rsp_rdata %h, expected %h", rd_at_accept, exp_hold); end
    while (cyc < t2 + L + 3) @(negedge clk);
    n = count_rsp_after(t1);
    foreach (rsp_log[i]) if (rsp_log[i].t > t1 && first.t < 0) first = rsp_log[i];
    checks++;
    if (n != (ACK ? 2 : 1)) begin errors++; $display("FAIL wa_count: got %0d pulses, expected %0d", n, ACK ? 2 : 1); end
    checks++;
    if (first.t !== (ACK ? t1 + L + 1 : t2 + L + 1))
      begin errors++; $display("FAIL wa_time: first rsp at %0d, expected %0d", first.t, ACK ? t1 + L + 1 : t2 + L + 1); end
    checks++;
    if (first.d !== 32'hCAFEF00D) begin errors++; $display("FAIL wa_data: got %h, expected cafef00d", first.d); end
    checks++;
    if (rsp_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL wa_readback: got %h, expected cafef00d", rsp_rdata); end
    held_rdata = 32'hCAFEF00D;
  endtask

  task automatic test_busy_request;
    int t0, t1, n;
    rsp_t a, b;
    a = '{t: -1, v: '0, d: '0};
    b = a;
    @(posedge clk);
    #1;
    drive(0, 1'b0, 10'h010, 32'h0);
    req_valid[0] = 1'b1;
    wait_ready(0, "bz_req0", t0);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    drive(1, 1'b0, 10'h3FC, 32'h0);
    req_valid[1] = 1'b1;
    wait_ready(1, "bz_req1", t1);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    last_grant = 1;
    if (t0 < 0 || t1 < 0) return;
    checks++;
    if (t1 != t0 + L + 2) begin errors++; $display("FAIL bz_accept: req1 accepted at +%0d, expected +%0d", t1 - t0, L + 2); end
    while (cyc < t1 + L + 3) @(negedge clk);
    n = 0;
    foreach (rsp_log[i]) if (rsp_log[i].t > t0) begin if (n == 0) a = rsp_log[i]; else b = rsp_log[i]; n++; end
    checks++;
    if (n != 2) begin errors++; $display("FAIL bz_count: got %0d pulses, expected 2", n); end
    checks++;
    if (a.t !== t0 + L + 1 || a.v !== 2'b01 || a.d !== model_mem[word_of(10'h010)])
      begin errors++; $display("FAIL bz_rsp0: t=%0d v=%b d=%h, expected t=%0d v=01 d=%h", a.t, a.v, a.d, t0 + L + 1, model_mem[word_of(10'h010)]); end
    checks++;
    if (b.t !== t1 + L + 1 || b.v !== 2'b10 || b.d !== model_mem[word_of(10'h3FC)])
      begin errors++; $display("FAIL bz_rsp1: t=%0d v=%b d=%h, expected t=%0d v=10 d=%h", b.t, b.v, b.d, t1 + L + 1, model_mem[word_of(10'h3FC)]); end
    held_rdata = model_mem[word_of(10'h3FC)];
  endtask

  task automatic test_reset_mid;
    int t;
    logic [DATA_W-1:0] v0;
    v0 = $urandom;
    if (v0 == 32'h12345678) v0 = v0 ^ 32'h1;
    txn(0, 1'b1, 10'h020, v0, "rm_pre");
    @(posedge clk);
    #1;
    drive(0, 1'b1, 10'h020, 32'h12345678);
    req_valid[0] = 1'b1;
    wait_ready(0, "rm_write", t);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b, expected 0", busy); end
    checks++; if (rsp_rdata !== '0) begin errors++; $display("FAIL rm_rdata: got %h, expected 0", rsp_rdata); end
    @(posedge clk);
    #1 reset = 1'b0;
    last_grant = NUM_REQ - 1;
    held_rdata = '0;
    repeat (L + 3) @(negedge clk);
    checks++;
    if (count_rsp_after(t) != 0)
      begin errors++; $display("FAIL rm_no_rsp: got %0d pulses, expected 0", count_rsp_after(t)); end
    // The aborted write must not land: the model still holds v0.
    txn(1, 1'b0, 10'h020, 32'h0, "rm_read");
  endtask

  task automatic test_random;
    logic [ADDR_W-1:0] pool [6];
    for (int i = 0; i < 6; i++) begin
      pool[i] = {8'($urandom_range(0, 255)), 2'b00};
      txn(i % NUM_REQ, 1'b1, pool[i], $urandom, "rnd_init");
    end
    for (int i = 0; i < 24; i++) begin
      int r;
      bit we;
      logic [ADDR_W-1:0] a;
      r  = $urandom_range(0, NUM_REQ - 1);
      we = ($urandom_range(0, 2) == 0);
      a  = pool[$urandom_range(0, 5)] | ADDR_W'($urandom_range(0, 3));
      txn(r, we, a, $urandom, we ? "rnd_write" : "rnd_read");
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_arbitration();
    test_throughput();
    test_write_ack();
    test_busy_request();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
